// File: rtl/udp_stack_pkg.sv
// Shared types and constants for the UDP/IP stack ARP resolution path.
package udp_stack_pkg;

    localparam int unsigned IP_W  = 32;
    localparam int unsigned MAC_W = 48;

    // Default ARP timing at 125 MHz.
    localparam int unsigned ARP_TIMEOUT_CYC = 125000;
    localparam int unsigned ARP_MAX_RETRY   = 3;
    localparam int unsigned ARP_HOLDOFF_CYC = 1250000;

    typedef enum logic [2:0] {
        ARP_IDLE    = 3'd0,
        ARP_SEND    = 3'd1,
        ARP_WAIT    = 3'd2,
        ARP_DONE    = 3'd3,
        ARP_HOLDOFF = 3'd4
    } arp_state_e;

    // Larger of two unsigned values.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..v, never less than one.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/arp_sched_timer.sv
// Loadable saturating down-counter with a zero flag.
module arp_sched_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_user_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over decrement; decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_user_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/arp_resolve_sched.sv
// ARP resolution sequencer: one outstanding miss, request/retry/timeout, then result.
module arp_resolve_sched
    import udp_stack_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = ARP_TIMEOUT_CYC,
    parameter int unsigned MAX_RETRY   = ARP_MAX_RETRY,
    parameter int unsigned HOLDOFF_CYC = ARP_HOLDOFF_CYC
) (
    input  logic             clk_user_i,
    input  logic             reset_i,
    input  logic             miss_vld_i,
    input  logic [IP_W-1:0]  miss_ip_i,
    output logic             miss_rdy_o,
    input  logic             learn_en_i,
    input  logic [IP_W-1:0]  learn_ip_i,
    input  logic [MAC_W-1:0] learn_mac_i,
    output logic             request_send_en_o,
    output logic [IP_W-1:0]  request_ip_addr_o,
    output logic             done_o,
    output logic             done_ok_o,
    output logic [IP_W-1:0]  done_ip_o,
    output logic [MAC_W-1:0] done_mac_o,
    output logic             busy_o
);

    localparam int unsigned TMR_W = cnt_width(max_u(TIMEOUT_CYC, HOLDOFF_CYC));
    localparam int unsigned RTY_W = cnt_width(MAX_RETRY);

    arp_state_e          state_q, state_d;
    logic [IP_W-1:0]     req_ip_q, req_ip_d;
    logic [MAC_W-1:0]    mac_q, mac_d;
    logic                ok_q, ok_d;
    logic [RTY_W-1:0]    retry_q, retry_d;

    logic                miss_rdy_q, miss_rdy_d;
    logic                send_q, send_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                done_ok_q, done_ok_d;
    logic [IP_W-1:0]     done_ip_q, done_ip_d;
    logic [MAC_W-1:0]    done_mac_q, done_mac_d;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_dec;
    logic                tmr_zero;
    logic                learn_hit;

    arp_sched_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_user_i (clk_user_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_c     (tmr_zero)
    );

    assign learn_hit = learn_en_i && (learn_ip_i == req_ip_q);

    // Next state, latches, timer control, and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        req_ip_d = req_ip_q;
        mac_d    = mac_q;
        ok_d     = ok_q;
        retry_d  = retry_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        case (state_q)
            ARP_IDLE: begin
                // miss_rdy_q gates acceptance so the first cycle after reset is not ready.
                if (miss_vld_i && miss_rdy_q) begin
                    req_ip_d = miss_ip_i;
                    mac_d    = '0;
                    ok_d     = 1'b0;
                    retry_d  = '0;
                    state_d  = ARP_SEND;
                end
            end
            ARP_SEND: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
                if (learn_hit) begin
                    mac_d   = learn_mac_i;
                    ok_d    = 1'b1;
                    state_d = ARP_DONE;
                end else begin
                    state_d = ARP_WAIT;
                end
            end
            ARP_WAIT: begin
                // A match beats a simultaneous expiry.
                if (learn_hit) begin
                    mac_d   = learn_mac_i;
                    ok_d    = 1'b1;
                    state_d = ARP_DONE;
                end else if (tmr_zero) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        if (retry_q != {RTY_W{1'b1}}) begin
                            retry_d = retry_q + RTY_W'(1);
                        end
                        state_d = ARP_SEND;
                    end else begin
                        ok_d    = 1'b0;
                        state_d = ARP_DONE;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ARP_DONE: begin
                if (ok_q) begin
                    state_d = ARP_IDLE;
                end else begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLDOFF_CYC - 1);
                    state_d  = ARP_HOLDOFF;
                end
            end
            ARP_HOLDOFF: begin
                if (tmr_zero) begin
                    state_d = ARP_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ARP_IDLE;
            end
        endcase

        miss_rdy_d = (state_d == ARP_IDLE);
        send_d     = (state_d == ARP_SEND);
        busy_d     = (state_d != ARP_IDLE);
        done_d     = (state_d == ARP_DONE);
        done_ok_d  = done_d && ok_d;
        done_ip_d  = done_d ? req_ip_d : '0;
        done_mac_d = (done_d && ok_d) ? mac_d : '0;
    end

    // State, latches and output registers; reset aborts any resolution in flight.
    always_ff @(posedge clk_user_i) begin
        if (reset_i) begin
            state_q    <= ARP_IDLE;
            req_ip_q   <= '0;
            mac_q      <= '0;
            ok_q       <= 1'b0;
            retry_q    <= '0;
            miss_rdy_q <= 1'b0;
            send_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_ok_q  <= 1'b0;
            done_ip_q  <= '0;
            done_mac_q <= '0;
        end else begin
            state_q    <= state_d;
            req_ip_q   <= req_ip_d;
            mac_q      <= mac_d;
            ok_q       <= ok_d;
            retry_q    <= retry_d;
            miss_rdy_q <= miss_rdy_d;
            send_q     <= send_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            done_ok_q  <= done_ok_d;
            done_ip_q  <= done_ip_d;
            done_mac_q <= done_mac_d;
        end
    end

    assign miss_rdy_o        = miss_rdy_q;
    assign request_send_en_o = send_q;
    assign request_ip_addr_o = req_ip_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign done_ok_o         = done_ok_q;
    assign done_ip_o         = done_ip_q;
    assign done_mac_o        = done_mac_q;

endmodule
